vx_barrier_ctl: RTL

VX_BARRIER_CTL -- requirements
Module: VX_barrier_ctl

---
 rtl/vx_barrier_ctl_pkg.sv | 17 +
 rtl/vx_barrier_ctl_if.sv | 34 +++
 rtl/vx_barrier_ctl_slot.sv | 51 +++++
 rtl/vx_barrier_ctl.sv | 98 +++++++++
 4 files changed

// File: rtl/vx_barrier_ctl_pkg.sv
// Shared GPU barrier types and width helpers for the barrier controller slice.
package vx_barrier_ctl_pkg;

  localparam int DEF_NUM_WARPS    = 4;
  localparam int DEF_NUM_BARRIERS = 4;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // UP(): a width of at least one bit.
  function automatic int up_bits(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/vx_barrier_ctl_if.sv
// Barrier arrival / release bundle between the GPU issue unit and the barrier controller.
interface vx_barrier_ctl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  import vx_barrier_ctl_pkg::*;

  localparam int NW_BITS = clog2_up(NUM_WARPS);
  localparam int NB_BITS = clog2_up(NUM_BARRIERS);
  localparam int SZ_BITS = up_bits(NW_BITS);

  // Handshake: barrier_valid is a one-cycle arrival with no ready; the
  // controller accepts every arrival. release_valid is a one-cycle pulse
  // with release_mask qualified by it (zero otherwise).
  logic                 barrier_valid;
  logic [NW_BITS-1:0]   barrier_wid;
  logic [NB_BITS-1:0]   barrier_id;
  logic [SZ_BITS-1:0]   barrier_size_m1;
  logic [NUM_WARPS-1:0] stalled_mask;
  logic                 release_valid;
  logic [NUM_WARPS-1:0] release_mask;
  logic [31:0]          perf_releases;

  modport master (
    output barrier_valid, barrier_wid, barrier_id, barrier_size_m1,
    input  stalled_mask, release_valid, release_mask, perf_releases
  );

  modport slave (
    input  barrier_valid, barrier_wid, barrier_id, barrier_size_m1,
    output stalled_mask, release_valid, release_mask, perf_releases
  );

endinterface

// File: rtl/vx_barrier_ctl_slot.sv
// One barrier ID: arrival mask, arrival counter and completion compare.
module vx_barrier_ctl_slot #(
  parameter int NUM_WARPS = 4,
  parameter int NW_BITS   = 2,
  parameter int SZ_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [SZ_BITS-1:0]   size_m1,
  output logic                 hit,
  output logic [NUM_WARPS-1:0] wmask,
  output logic [NUM_WARPS-1:0] wmask_nxt,
  output logic [NUM_WARPS-1:0] rel_mask
);

  logic [SZ_BITS-1:0]   cnt;
  logic [SZ_BITS-1:0]   cnt_nxt;
  logic [NUM_WARPS-1:0] wid_oh;

  assign wid_oh   = {{(NUM_WARPS-1){1'b0}}, 1'b1} << wid;
  // Completion compares against this request's size; no size is stored.
  assign hit      = sel && (cnt == size_m1);
  assign rel_mask = wmask | wid_oh;

  always_comb begin
    wmask_nxt = wmask;
    cnt_nxt   = cnt;
    if (sel) begin
      if (hit) begin
        wmask_nxt = '0;
        cnt_nxt   = '0;
      end else begin
        wmask_nxt = wmask | wid_oh;
        cnt_nxt   = cnt + SZ_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wmask <= '0;
      cnt   <= '0;
    end else begin
      wmask <= wmask_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vx_barrier_ctl.sv
// Warp barrier controller: per-ID slots, ORed stall mask, registered release pulse.
module vx_barrier_ctl
  import vx_barrier_ctl_pkg::*;
#(
  parameter int NUM_WARPS    = DEF_NUM_WARPS,
  parameter int NUM_BARRIERS = DEF_NUM_BARRIERS
) (
  input  logic             clk,
  input  logic             reset,
  vx_barrier_ctl_if.slave  bus
);

  localparam int NW_BITS = clog2_up(NUM_WARPS);
  localparam int NB_BITS = clog2_up(NUM_BARRIERS);
  localparam int SZ_BITS = up_bits(NW_BITS);

  logic [NUM_WARPS-1:0]    wid_oh;
  logic [NUM_WARPS-1:0]    wmask_all;
  logic                    dup;
  logic                    accept;
  logic [NUM_BARRIERS-1:0] slot_sel;
  logic [NUM_BARRIERS-1:0] slot_hit;
  logic [NUM_WARPS-1:0]    slot_wmask     [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_wmask_nxt [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    slot_rel       [NUM_BARRIERS];
  logic                    any_hit;
  logic [NUM_WARPS-1:0]    rel_mux;
  logic [NUM_WARPS-1:0]    stall_nxt;

  assign wid_oh = {{(NUM_WARPS-1){1'b0}}, 1'b1} << bus.barrier_wid;
  // A warp already waiting anywhere cannot arrive again; drop it untouched.
  assign dup    = |(wmask_all & wid_oh);
  assign accept = bus.barrier_valid && !dup;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
    assign slot_sel[b] = accept && (bus.barrier_id == NB_BITS'(b));

    vx_barrier_ctl_slot #(
      .NUM_WARPS (NUM_WARPS),
      .NW_BITS   (NW_BITS),
      .SZ_BITS   (SZ_BITS)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .sel       (slot_sel[b]),
      .wid       (bus.barrier_wid),
      .size_m1   (bus.barrier_size_m1),
      .hit       (slot_hit[b]),
      .wmask     (slot_wmask[b]),
      .wmask_nxt (slot_wmask_nxt[b]),
      .rel_mask  (slot_rel[b])
    );
  end

  always_comb begin
    wmask_all = '0;
    stall_nxt = '0;
    rel_mux   = '0;
    any_hit   = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      wmask_all = wmask_all | slot_wmask[b];
      stall_nxt = stall_nxt | slot_wmask_nxt[b];
      if (slot_hit[b]) begin
        any_hit = 1'b1;
        rel_mux = rel_mux | slot_rel[b];
      end
    end
  end

  // Outputs are registered copies of the post-update state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stalled_mask  <= '0;
      bus.release_valid <= 1'b0;
      bus.release_mask  <= '0;
      bus.perf_releases <= '0;
    end else begin
      bus.stalled_mask  <= stall_nxt;
      bus.release_valid <= any_hit;
      bus.release_mask  <= any_hit ? rel_mux : '0;
      if (any_hit) begin
        bus.perf_releases <= bus.perf_releases + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && bus.barrier_valid) begin
      assert (!dup)
        else $warning("vx_barrier_ctl: duplicate arrival from warp %0d ignored", bus.barrier_wid);
      assert (int'(bus.barrier_size_m1) <= NUM_WARPS - 1)
        else $warning("vx_barrier_ctl: size_m1 %0d exceeds warp count", bus.barrier_size_m1);
    end
  end
`endif

endmodule
